fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch stage between the MMU instruction read port and decode 1st.
- Issues sequential PC read requests to the MMU and accepts in-order responses.
- Buffers responses in a small first-word-fall-through FIFO and presents one instruction per cycle to decode.
- Redirect via FLUSH/NEW_PC empties the queue and discards stale in-flight responses by address match.

Parameters:
- START_ADDR, 32'h0000_0000, PC loaded at reset.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- FLUSH  in  1  redirect request from exec/branch.
- NEW_PC  in  32  redirect target; valid with FLUSH.
- STALL  in  1  decode cannot accept this cycle.
- MEM_WAIT  in  1  MMU busy; no request may issue.
- INST_RDEN  out  1  read request to MMU.
- INST_RIADDR  out  32  request address.
- INST_RVALID  in  1  MMU response valid.
- INST_ROADDR  in  32  address of the response.
- INST_RDATA  in  32  instruction word.
- INST_VALID  out  1  instruction available to decode.
- INST_PC  out  32  PC of presented instruction.
- INST_DATA  out  32  presented instruction.

Behaviour:
- Reset (RST=0, async):
  - pc=START_ADDR, expect_addr=START_ADDR.
  - FIFO count=0, head=tail=0, inflight=0.
  - INST_RDEN=0, INST_RIADDR=START_ADDR, INST_VALID=0, INST_PC=0, INST_DATA=0.
  - Reset asserted mid-operation discards all entries and in-flight state immediately.
- Counter widths: count and inflight are $clog2(DEPTH)+1 bits; head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Issue: INST_RDEN is combinational, = !FLUSH && !MEM_WAIT && (count+inflight < DEPTH).
  - INST_RIADDR = pc.
  - On issue: pc <= pc+4 and inflight +1.
- Response (INST_RVALID=1): inflight decrements by 1, unless an issue occurs in the same cycle (net 0).
  - Accept iff INST_ROADDR == expect_addr && !FLUSH: write {ROADDR, RDATA} at tail, tail+1, count+1, expect_addr+4.
  - Otherwise drop (stale response after a redirect).
  - Responses are in order, at most one per cycle, with variable latency ≥1.
- Output is first-word-fall-through from head:
  - INST_VALID = (count != 0).
  - INST_PC/INST_DATA = head entry while valid; hold last values while empty.
  - Pop when INST_VALID && !STALL: head+1, count-1.
  - Push and pop in the same cycle: count unchanged.
- FLUSH (1 cycle or held), takes priority over everything:
  - pc <= NEW_PC, expect_addr <= NEW_PC.
  - count/head/tail cleared; no issue, no accept, no pop that cycle.
  - inflight is not cleared: outstanding responses still arrive and are decremented and dropped by address mismatch.
  - INST_VALID=0 the cycle after FLUSH.
- Full: count+inflight == DEPTH blocks issue, so the FIFO never overflows; a push into a full FIFO is impossible by construction.
- Empty with STALL=0: no pop occurs.
- PC wrap: 32'hFFFF_FFFC + 4 -> 0, no special handling.
- Redirect to the same address as a stale response: the response is accepted. This is intentional, because the data is identical.

Test Plan:
- Reset release with STALL=0 and a 1-cycle MMU returning word = addr ^ 32'hA5A5_0000 -> INST_RDEN rises the first cycle; decode sees PCs 0, 4, 8, 12... consecutively, one per cycle, with matching data.
- STALL held 10 cycles with DEPTH=4 -> exactly 4 requests outstanding or buffered; INST_RDEN=0 afterwards; INST_PC holds 0; release -> PCs 0, 4, 8, 12, 16 with no gap or duplicate.
- MEM_WAIT asserted cycles 3-6 -> no INST_RDEN during those cycles; PC sequence continuous after release.
- FLUSH with NEW_PC=32'h100 while 3-cycle-latency MMU has 2 requests in flight (0x8, 0xC) -> those responses dropped; first INST_VALID shows PC 0x100, then 0x104; inflight returns to 0.
- FLUSH asserted on the same cycle as a response and a pop -> FIFO empty next cycle, no stale entry ever presented.
- RST pulled low asynchronously mid-stream (between clock edges) -> INST_VALID=0 immediately; after release, fetch restarts at START_ADDR.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues sequential PC reads to the MMU, buffers in-order
// responses in a first-word-fall-through FIFO and presents one instruction per cycle.
module fetch_queue #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic [31:0] NEW_PC,
  input  logic        STALL,
  input  logic        MEM_WAIT,
  output logic        INST_RDEN,
  output logic [31:0] INST_RIADDR,
  input  logic        INST_RVALID,
  input  logic [31:0] INST_ROADDR,
  input  logic [31:0] INST_RDATA,
  output logic        INST_VALID,
  output logic [31:0] INST_PC,
  output logic [31:0] INST_DATA
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   expect_addr;
  logic [31:0]   hold_pc;
  logic [31:0]   hold_data;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [31:0]   fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];

  logic          issue;
  logic          accept;
  logic          valid;
  logic          pop;
  logic [CW:0]   occupancy;

  // Entries buffered plus requests still outstanding must never exceed DEPTH,
  // which is what guarantees a response always finds a free slot.
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign issue     = RST && !FLUSH && !MEM_WAIT && (occupancy < DEPTH_L);
  assign accept    = INST_RVALID && (INST_ROADDR == expect_addr) && !FLUSH;
  assign valid     = (count != '0);
  assign pop       = valid && !STALL && !FLUSH;

  assign INST_RDEN   = issue;
  assign INST_RIADDR = pc;
  assign INST_VALID  = valid;
  assign INST_PC     = valid ? fifo_addr[head] : hold_pc;
  assign INST_DATA   = valid ? fifo_data[head] : hold_data;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc          <= START_ADDR;
      expect_addr <= START_ADDR;
      count       <= '0;
      inflight    <= '0;
      head        <= '0;
      tail        <= '0;
      hold_pc     <= '0;
      hold_data   <= '0;
    end else begin
      if (FLUSH) begin
        pc          <= NEW_PC;
        expect_addr <= NEW_PC;
      end else begin
        if (issue)  pc          <= pc + 32'd4;
        if (accept) expect_addr <= expect_addr + 32'd4;
      end

      // Outstanding responses survive a redirect; they drain here and are
      // rejected by the address compare instead.
      case ({issue, INST_RVALID})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      if (FLUSH) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (accept) tail <= tail + AW'(1);
        if (pop)    head <= head + AW'(1);
        if (accept && !pop)      count <= count + CW'(1);
        else if (!accept && pop) count <= count - CW'(1);
      end

      if (valid) begin
        hold_pc   <= fifo_addr[head];
        hold_data <= fifo_data[head];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      fifo_addr[tail] <= INST_ROADDR;
      fifo_data[tail] <= INST_RDATA;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a behavioural in-order MMU of adjustable latency.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall;
  logic        mem_wait;
  logic        inst_rden;
  logic [31:0] inst_riaddr;
  logic        inst_rvalid = 1'b0;
  logic [31:0] inst_roaddr = 32'h0;
  logic [31:0] inst_rdata  = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  logic        drv_rst;
  logic        drv_flush;
  logic [31:0] drv_new_pc;
  logic        drv_stall;
  logic        drv_mem_wait;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int issued = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t pending[$];

  fetch_queue #(.START_ADDR(32'h0000_0000), .DEPTH(4)) dut (
    .CLK(clk),
    .RST(rst),
    .FLUSH(flush),
    .NEW_PC(new_pc),
    .STALL(stall),
    .MEM_WAIT(mem_wait),
    .INST_RDEN(inst_rden),
    .INST_RIADDR(inst_riaddr),
    .INST_RVALID(inst_rvalid),
    .INST_ROADDR(inst_roaddr),
    .INST_RDATA(inst_rdata),
    .INST_VALID(inst_valid),
    .INST_PC(inst_pc),
    .INST_DATA(inst_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MMU model: settles 1 ns after the falling edge, after stimulus has been driven.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (!rst) begin
      pending.delete();
      issued      = 0;
      inst_rvalid = 1'b0;
      inst_roaddr = 32'h0;
      inst_rdata  = 32'h0;
    end else begin
      if (pending.size() > 0 && pending[0].due <= cyc) begin
        inst_rvalid = 1'b1;
        inst_roaddr = pending[0].addr;
        inst_rdata  = pending[0].addr ^ 32'hA5A5_0000;
        void'(pending.pop_front());
      end else begin
        inst_rvalid = 1'b0;
      end
      if (inst_rden) begin
        pending.push_back('{addr: inst_riaddr, due: cyc + lat});
        issued++;
      end
    end
  end

  task automatic apply_stimulus();
    @(negedge clk);
    rst      = drv_rst;
    flush    = drv_flush;
    new_pc   = drv_new_pc;
    stall    = drv_stall;
    mem_wait = drv_mem_wait;
    #3;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic expect_run(input logic [31:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] e;
      e = first + 32'(4 * k);
      apply_stimulus();
      check_output("run_valid", {31'b0, inst_valid}, 32'd1);
      check_output("run_pc", inst_pc, e);
      check_output("run_data", inst_data, e ^ 32'hA5A5_0000);
    end
  endtask

  initial begin
    drv_rst = 1'b0; drv_flush = 1'b0; drv_new_pc = 32'h0;
    drv_stall = 1'b0; drv_mem_wait = 1'b0;
    rst = 1'b0; flush = 1'b0; new_pc = 32'h0; stall = 1'b0; mem_wait = 1'b0;

    apply_stimulus();
    apply_stimulus();
    check_output("reset_rden", {31'b0, inst_rden}, 32'd0);
    check_output("reset_riaddr", inst_riaddr, 32'h0);
    check_output("reset_valid", {31'b0, inst_valid}, 32'd0);
    check_output("reset_pc", inst_pc, 32'h0);
    check_output("reset_data", inst_data, 32'h0);

    // Streaming with a 1-cycle MMU
    drv_rst = 1'b1;
    apply_stimulus();
    check_output("first_rden", {31'b0, inst_rden}, 32'd1);
    check_output("first_riaddr", inst_riaddr, 32'h0);
    apply_stimulus();
    check_output("first_valid_lat", {31'b0, inst_valid}, 32'd0);
    expect_run(32'h0, 6);

    // MEM_WAIT for four cycles
    drv_mem_wait = 1'b1;
    apply_stimulus();
    check_output("mw_rden0", {31'b0, inst_rden}, 32'd0);
    check_output("mw_pc0", inst_pc, 32'd24);
    apply_stimulus();
    check_output("mw_rden1", {31'b0, inst_rden}, 32'd0);
    check_output("mw_pc1", inst_pc, 32'd28);
    apply_stimulus();
    check_output("mw_rden2", {31'b0, inst_rden}, 32'd0);
    check_output("mw_valid2", {31'b0, inst_valid}, 32'd0);
    check_output("mw_hold_pc", inst_pc, 32'd28);
    apply_stimulus();
    check_output("mw_rden3", {31'b0, inst_rden}, 32'd0);
    drv_mem_wait = 1'b0;
    apply_stimulus();
    check_output("mw_resume_rden", {31'b0, inst_rden}, 32'd1);
    check_output("mw_resume_addr", inst_riaddr, 32'd32);
    apply_stimulus();
    check_output("mw_resume_valid", {31'b0, inst_valid}, 32'd0);
    expect_run(32'd32, 3);

    // Redirect with two requests in flight on a 3-cycle MMU
    lat = 3;
    drv_rst = 1'b0;
    apply_stimulus();
    drv_rst = 1'b1;
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    check_output("l3_valid_c3", {31'b0, inst_valid}, 32'd0);
    apply_stimulus();
    check_output("l3_pc_c4", inst_pc, 32'h0);
    drv_flush = 1'b1; drv_new_pc = 32'h100;
    apply_stimulus();
    check_output("fl_pc_before", inst_pc, 32'h4);
    check_output("fl_rden", {31'b0, inst_rden}, 32'd0);
    drv_flush = 1'b0;
    apply_stimulus();
    check_output("fl_valid_after", {31'b0, inst_valid}, 32'd0);
    check_output("fl_riaddr", inst_riaddr, 32'h100);
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    check_output("fl_valid_c9", {31'b0, inst_valid}, 32'd0);
    apply_stimulus();
    check_output("fl_pc_100", inst_pc, 32'h100);
    check_output("fl_data_100", inst_data, 32'h100 ^ 32'hA5A5_0000);
    drv_mem_wait = 1'b1;
    apply_stimulus();
    check_output("fl_pc_104", inst_pc, 32'h104);
    apply_stimulus();
    check_output("fl_pc_108", inst_pc, 32'h108);
    apply_stimulus();
    check_output("fl_pc_10c", inst_pc, 32'h10C);
    check_output("fl_inflight", 32'(dut.inflight), 32'd0);

    // Redirect coinciding with a response and a pop
    drv_mem_wait = 1'b0;
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    check_output("co_pc_110", inst_pc, 32'h110);
    drv_flush = 1'b1; drv_new_pc = 32'h200;
    apply_stimulus();
    check_output("co_valid_flush", {31'b0, inst_valid}, 32'd1);
    check_output("co_pc_114", inst_pc, 32'h114);
    check_output("co_rvalid", {31'b0, inst_rvalid}, 32'd1);
    drv_flush = 1'b0;
    apply_stimulus();
    check_output("co_valid_after", {31'b0, inst_valid}, 32'd0);
    check_output("co_riaddr", inst_riaddr, 32'h200);
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    check_output("co_valid_d9", {31'b0, inst_valid}, 32'd0);
    apply_stimulus();
    check_output("co_pc_200", inst_pc, 32'h200);
    apply_stimulus();
    check_output("co_pc_204", inst_pc, 32'h204);

    // Asynchronous reset between clock edges, then restart under STALL
    @(posedge clk);
    #2;
    drv_rst = 1'b0;
    rst = 1'b0;
    #1;
    check_output("ar_valid", {31'b0, inst_valid}, 32'd0);
    check_output("ar_rden", {31'b0, inst_rden}, 32'd0);
    lat = 1;
    drv_stall = 1'b1;
    apply_stimulus();
    apply_stimulus();
    check_output("ar_riaddr", inst_riaddr, 32'h0);
    check_output("ar_pc", inst_pc, 32'h0);
    drv_rst = 1'b1;
    apply_stimulus();
    check_output("st_rden_c0", {31'b0, inst_rden}, 32'd1);
    check_output("st_riaddr_c0", inst_riaddr, 32'h0);
    repeat (9) apply_stimulus();
    check_output("st_rden_c9", {31'b0, inst_rden}, 32'd0);
    check_output("st_valid_c9", {31'b0, inst_valid}, 32'd1);
    check_output("st_pc_c9", inst_pc, 32'h0);
    check_output("st_issued", 32'(issued), 32'd4);
    drv_stall = 1'b0;
    expect_run(32'h0, 6);

    // Redirect near the top of the address space
    drv_flush = 1'b1; drv_new_pc = 32'hFFFF_FFF8;
    apply_stimulus();
    check_output("wr_rden_flush", {31'b0, inst_rden}, 32'd0);
    drv_flush = 1'b0;
    apply_stimulus();
    check_output("wr_rden", {31'b0, inst_rden}, 32'd1);
    check_output("wr_riaddr", inst_riaddr, 32'hFFFF_FFF8);
    apply_stimulus();
    check_output("wr_valid", {31'b0, inst_valid}, 32'd0);
    expect_run(32'hFFFF_FFF8, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
